// File: rtl/fdiv_arb.sv
// Round-robin arbiter that time-shares one iterative fp32 divider core.
// Latches operands, pulses core_start, counts latency, returns result.
module fdiv_arb #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int CORE_LAT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_x,
    input  logic [32*NREQ-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_rslt,
    output logic [4:0]         rsp_flag,
    output logic               core_start,
    output logic [31:0]        core_x,
    output logic [31:0]        core_y,
    input  logic [31:0]        core_rslt,
    input  logic [4:0]         core_flag,
    output logic               busy
);
    localparam int CW = $clog2(CORE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] id;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] gidx;
    logic           gnt_any;
    logic           hs;
    logic           lat_hit;
    logic [31:0]    gx;
    logic [31:0]    gy;

    // Search starts just after the last winner and wraps at NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gidx    = last;
        cand    = last;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gidx    = cand;
            end
        end
    end

    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gidx) begin
                gx = req_x[i*32 +: 32];
                gy = req_y[i*32 +: 32];
            end
        end
    end

    assign hs        = (state == IDLE) && !reset && gnt_any;
    assign req_ready = hs ? (NREQ'(1) << gidx) : '0;
    assign lat_hit   = (cnt == CW'(CORE_LAT));

    assign core_start = (state == RUN) && (cnt == '0) && !reset;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (hs) state_nx = RUN;
            RUN:  if (lat_hit) state_nx = DONE;
            DONE: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            last      <= IDW'(NREQ - 1);
            id        <= '0;
            core_x    <= '0;
            core_y    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rslt  <= '0;
            rsp_flag  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        core_x <= gx;
                        core_y <= gy;
                        id     <= gidx;
                        last   <= gidx;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (lat_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                        rsp_rslt  <= core_rslt;
                        rsp_flag  <= core_flag;
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_arb.sv
// Bench for fdiv_arb: stand-in divider core, arbitration reference
// model and a response scoreboard checked by an independent monitor.
module tb_fdiv_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_x;
    logic [32*NREQ-1:0] req_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_rslt;
    logic [4:0]         rsp_flag;
    logic               core_start;
    logic [31:0]        core_x;
    logic [31:0]        core_y;
    logic [31:0]        core_rslt;
    logic [4:0]         core_flag;
    logic               busy;

    fdiv_arb #(.NREQ(NREQ), .IDW(IDW), .CORE_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_rslt(rsp_rslt), .rsp_flag(rsp_flag),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_rslt(core_rslt), .core_flag(core_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in divider: exact for the directed operand pairs,
    // an arbitrary mixing function otherwise.
    function automatic logic [36:0] cref(logic [31:0] x, logic [31:0] y);
        logic [31:0] r;
        if (x == 32'h40400000 && y == 32'h40000000) r = 32'h3FC00000;
        else if (x == y) r = 32'h3F800000;
        else r = (x * 3) ^ {y[15:0], y[31:16]} ^ 32'h5A5A1234;
        return {x[4:0] ^ y[9:5], r};
    endfunction

    logic        cact = 1'b0;
    int          ck = 0;
    logic [31:0] csx = '0;
    logic [31:0] csy = '0;
    logic [36:0] cr;

    always @(posedge clk) begin
        if (reset) cact <= 1'b0;
        else if (core_start) begin
            cact <= 1'b1;
            ck   <= 1;
            csx  <= core_x;
            csy  <= core_y;
        end else if (cact) ck <= ck + 1;
    end

    always_comb begin
        cr        = cref(csx, csy);
        core_rslt = (cact && ck == LAT) ? cr[31:0] : 32'hDEADBEEF;
        core_flag = (cact && ck == LAT) ? cr[36:32] : 5'h1F;
    end

    // Requester side
    logic [NREQ-1:0] v = '0;
    logic [31:0]     xs[NREQ];
    logic [31:0]     ys[NREQ];
    int              gcnt[NREQ];
    int              dcnt[NREQ];
    bit              auto_rl = 0;
    bit              rnd = 0;

    assign req_valid = v;
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*32 +: 32] = xs[i];
            req_y[i*32 +: 32] = ys[i];
        end
    end

    // Reference model and scoreboard state
    typedef struct {
        int          id;
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;
    exp_t        sb[$];
    int          m_last = NREQ - 1;
    bit          m_idle = 1;
    bit          m_rspv = 0;
    bit          m_jr = 0;
    int          m_t = 0;
    logic [31:0] m_x = '0;
    logic [31:0] m_y = '0;
    bit          mon_en = 0;
    bit          fin_req = 0;
    bit          fin_done = 0;
    int          tmo_n = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic int pick(logic [NREQ-1:0] vv, int l);
        for (int k = 1; k <= NREQ; k++)
            if (vv[(l + k) % NREQ]) return (l + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] er;
        logic [36:0]     e;
        if (fin_req && !fin_done) begin
            chk("timeouts", 64'(tmo_n), 64'd0);
            chk("sb_drained", 64'(sb.size()), 64'd0);
            fin_done = 1;
        end else if (mon_en && reset) begin
            chk("rdy_in_reset", 64'(req_ready), 64'd0);
            chk("start_in_reset", 64'(core_start), 64'd0);
            m_idle = 1;
            m_rspv = 0;
            m_last = NREQ - 1;
            m_jr   = 1;
            sb.delete();
        end else if (mon_en) begin
            if (m_jr) begin
                chk("rst_rsp_id", 64'(rsp_id), 64'd0);
                chk("rst_rsp_rslt", 64'(rsp_rslt), 64'd0);
                chk("rst_rsp_flag", 64'(rsp_flag), 64'd0);
                chk("rst_core_x", 64'(core_x), 64'd0);
                chk("rst_core_y", 64'(core_y), 64'd0);
                m_jr = 0;
            end
            g  = pick(req_valid, m_last);
            er = '0;
            if (m_idle && g >= 0) er[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(!m_idle));
            chk("core_start", 64'(core_start), 64'(!m_idle && m_t == 1));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
            if (!m_idle) begin
                chk("core_x_hold", 64'(core_x), 64'(m_x));
                chk("core_y_hold", 64'(core_y), 64'(m_y));
            end
            if (rsp_valid && m_rspv) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'd0, 64'd1);
                end else begin
                    chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                    chk("rsp_rslt", 64'(rsp_rslt), 64'(sb[0].r));
                    chk("rsp_flag", 64'(rsp_flag), 64'(sb[0].f));
                end
            end
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) gcnt[i]++;
            // advance the model to the next cycle
            if (m_idle) begin
                if (g >= 0) begin
                    m_x = req_x[g*32 +: 32];
                    m_y = req_y[g*32 +: 32];
                    e   = cref(m_x, m_y);
                    sb.push_back('{g, e[31:0], e[36:32]});
                    m_last = g;
                    m_idle = 0;
                    m_t    = 1;
                end
            end else if (m_rspv) begin
                if (rsp_ready) begin
                    m_rspv = 0;
                    m_idle = 1;
                    if (sb.size() > 0) void'(sb.pop_front());
                end
            end else begin
                m_t++;
                if (m_t == LAT + 2) m_rspv = 1;
            end
        end
    end

    task automatic set_op(int i, logic [31:0] x, logic [31:0] y);
        v[i]  = 1'b1;
        xs[i] = x;
        ys[i] = y;
    endtask

    task automatic new_op(int i);
        logic [31:0] x;
        x = $urandom;
        set_op(i, x, ($urandom_range(7) == 0) ? x : $urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gcnt[i] != dcnt[i]) begin
                dcnt[i] = gcnt[i];
                if (auto_rl || (rnd && $urandom_range(1) == 0)) new_op(i);
                else begin
                    v[i]  = 1'b0;
                    xs[i] = $urandom;
                end
            end else if (rnd && !v[i] && $urandom_range(7) == 0) new_op(i);
        end
        if (rnd) rsp_ready = ($urandom_range(2) != 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            xs[i] = '0;
            ys[i] = '0;
            gcnt[i] = 0;
            dcnt[i] = 0;
        end
        reset     = 1'b1;
        rsp_ready = 1'b1;
        mon_en    = 1;
        repeat (3) tick();
        reset = 1'b0;

        set_op(0, 32'h40400000, 32'h40000000);
        repeat (25) tick();

        do_reset();
        for (int i = 0; i < NREQ; i++) new_op(i);
        auto_rl = 1;
        repeat (19 * 5) tick();
        auto_rl = 0;
        repeat (100) tick();

        do_reset();
        set_op(2, $urandom, $urandom);
        repeat (25) tick();
        set_op(1, $urandom, $urandom);
        set_op(3, $urandom, $urandom);
        repeat (45) tick();

        rsp_ready = 1'b0;
        set_op(0, $urandom, $urandom);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) tmo_n++;
        set_op(1, $urandom, $urandom);
        repeat (5) tick();
        rsp_ready = 1'b1;
        repeat (25) tick();

        set_op(0, $urandom, $urandom);
        n = 0;
        while (!(m_t == 8 && !m_idle) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) tmo_n++;
        v = '0;
        do_reset();
        set_op(0, 32'h40A00000, 32'h40A00000);
        repeat (25) tick();

        rnd = 1;
        repeat (1500) tick();
        rnd = 0;
        rsp_ready = 1'b1;
        repeat (200) tick();

        fin_req = 1;
        n = 0;
        while (!fin_done && n < 10) begin
            tick();
            n++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
